pipe_stage_buf: RTL and testbench
=================================

# pipe_stage_buf

Parametrised elastic pipeline-stage register with a valid/ready handshake, synchronous flush and bubble insertion. It is the next generation of the fixed IF_ID/ID_EX/EX_MEM/MEM_WB stage registers and is placed between any two pipeline stages. It holds up to DEPTH in-flight stage payloads, so an upstream stage keeps issuing for DEPTH cycles after downstream stalls. It presents a programmable bubble (NOP) payload whenever it is empty.

## Interface
- WIDTH, 32: payload width in bits (control bundle and/or instruction), ≥1.
- DEPTH, 2: number of entries; power of two, ≥2.
- BUBBLE, {WIDTH{1'b0}}: payload driven on out_data when empty (NOP/zeroed controls).
- Clk  input  1  clock, all state changes on rising edge.
- Reset  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous discard of all held entries (branch taken / hazard flush).
- in_valid  input  1  upstream presents a payload.
- in_ready  output  1  buffer can accept a payload this cycle.
- in_data  input  WIDTH  upstream payload.
- out_valid  output  1  out_data holds a real payload.
- out_ready  input  1  downstream consumes the payload this cycle.
- out_data  output  WIDTH  head payload, or BUBBLE when empty.
- occupancy  output  $clog2(DEPTH+1)  current entry count.
- stall_count  output  16  saturating upstream-stall counter (only with PIPE_STAGE_STATS_EN).

## Operation
- Storage: circular array of DEPTH entries; write pointer, read pointer (log2(DEPTH) bits, natural wrap), count register (0..DEPTH).
- in_ready = (count != DEPTH); depends only on state, never on out_ready.
- out_valid = (count != 0); out_data = mem[rd_ptr] when out_valid, else BUBBLE.
- push = in_valid & in_ready; pop = out_valid & out_ready.
- push only: mem[wr_ptr] <= in_data, wr_ptr+1, count+1.
- pop only: rd_ptr+1, count-1.
- push and pop together: both pointers advance, count unchanged. This is legal at any count 1..DEPTH-1.
- Full: in_ready=0. A pop in that cycle frees a slot, but the cycle's in_data is not accepted (no pass-through when full).
- Empty: a pop is impossible. in_data is not forwarded combinationally.
- flush=1 takes priority over push and pop: count, wr_ptr and rd_ptr go to 0; the same-cycle push is dropped; memory contents are don't-care. A payload already accepted is never partially visible after a flush.
- in_valid while in_ready=0: the upstream must hold in_data stable. The buffer samples nothing.
- occupancy = count.

## Timing
- Reset (async assert): count=0, pointers=0. Outputs settle immediately to out_valid=0, out_data=BUBBLE, in_ready=1, occupancy=0, stall_count=0. Deassertion is synchronous to Clk by the integrating design.
- Reset asserted mid-operation discards all entries exactly like flush, but without waiting for an edge.
- Latency: payload accepted at edge N appears on out_data/out_valid after edge N (1 cycle).
- Throughput: 1 payload per cycle sustained with out_ready=1.
- After out_ready drops, upstream can push DEPTH further payloads before in_ready=0. in_ready deasserts the cycle after the DEPTH-th push.
- flush at edge N: out_valid=0 and out_data=BUBBLE after edge N. in_ready=1 after edge N.

## Configuration
- PIPE_STAGE_STATS_EN defined: stall_count port exists. It increments on each edge where in_valid & ~in_ready, saturates at 16'hFFFF, and is cleared only by Reset (flush does not clear it).
- Undefined: stall_count port and counter are absent. All other behaviour is identical.

## Test plan
- Reset then idle, WIDTH=32, DEPTH=2, BUBBLE=32'hE1A00000 -> out_valid=0, out_data=32'hE1A00000, in_ready=1, occupancy=0.
- Streaming: push 0x11,0x22,0x33 on consecutive cycles with out_ready=1 -> out_data 0x11,0x22,0x33 on the following consecutive cycles, occupancy stays ≤1.
- Backpressure: out_ready=0, push 0xA,0xB,0xC -> 0xA and 0xB accepted, in_ready=0 after the second push, occupancy=2. 0xC is held by upstream. With STATS_EN, stall_count increments each stalled cycle. Raise out_ready -> order 0xA,0xB,0xC is preserved.
- Full + simultaneous pop: count=2, in_valid=1, out_ready=1 -> pop only, occupancy=1, push accepted the next cycle.
- Flush with concurrent push at occupancy=2 -> after the edge occupancy=0, out_data=BUBBLE, and the pushed payload never appears.
- Async Reset asserted mid-cycle with occupancy=1 -> out_valid falls before the next Clk edge. Pointer wrap: run 4·DEPTH payloads with alternating stalls and check that no loss or duplication occurs.

Source files
------------

// File: rtl/pipe_stage_buf.sv
// ---------------------------------------------------------------------------
// pipe_stage_buf
//
// Elastic pipeline-stage register with a valid/ready handshake. It sits
// between two pipeline stages and holds up to DEPTH in-flight payloads.
// It presents the BUBBLE (NOP) payload whenever it is empty.
//
// Parameters
//   WIDTH   payload width in bits (>= 1)
//   DEPTH   number of entries (power of two, >= 2)
//   BUBBLE  payload driven on out_data while empty
//
// Ports
//   clk          clock; all state changes on the rising edge
//   Reset        asynchronous active-high reset
//   flush        synchronous discard of every held entry
//   in_valid     upstream presents a payload
//   in_ready     buffer can accept a payload this cycle (state only)
//   in_data      upstream payload
//   out_valid    out_data holds a real payload
//   out_ready    downstream consumes the head payload this cycle
//   out_data     head payload, or BUBBLE when empty
//   occupancy    current entry count
//   stall_count  saturating count of cycles with in_valid & ~in_ready
//                (present only when PIPE_STAGE_STATS_EN is defined)
//
// Optional feature macro: PIPE_STAGE_STATS_EN
// ---------------------------------------------------------------------------
module pipe_stage_buf #(
    parameter int               WIDTH  = 32,
    parameter int               DEPTH  = 2,
    parameter logic [WIDTH-1:0] BUBBLE = {WIDTH{1'b0}}
) (
    input  logic                         clk,
    input  logic                         Reset,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WIDTH-1:0]             out_data,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy
`ifdef PIPE_STAGE_STATS_EN
    ,
    output logic [15:0]                  stall_count
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    logic push;
    logic pop;

    // Handshake is a pure function of the held state: in_ready never looks
    // at out_ready, so a full buffer does not pass a payload through.
    assign in_ready  = (count != CNT_W'(DEPTH));
    assign out_valid = (count != '0);
    assign out_data  = out_valid ? mem[rd_ptr] : BUBBLE;
    assign occupancy = count;

    assign push = in_valid & in_ready;
    assign pop  = out_valid & out_ready;

    // Control state: pointers wrap naturally at DEPTH (power of two).
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    // Payload storage carries no reset; a flushed push is never written so
    // it cannot resurface once the pointers start moving again.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr] <= in_data;
        end
    end

`ifdef PIPE_STAGE_STATS_EN
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Upstream stall statistics; flush deliberately leaves this untouched.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            stall_count <= '0;
        end else if (in_valid && !in_ready) begin
            stall_count <= sat_inc16(stall_count);
        end
    end
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
module tb_pipe_stage_buf;

    localparam int               WIDTH  = 32;
    localparam int               DEPTH  = 2;
    localparam logic [WIDTH-1:0] BUBBLE = 32'hE1A00000;
    localparam int               CNT_W  = $clog2(DEPTH+1);

    logic             clk;
    logic             Reset;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [CNT_W-1:0] occupancy;
`ifdef PIPE_STAGE_STATS_EN
    logic [15:0]      stall_count;
`endif

    pipe_stage_buf #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .BUBBLE(BUBBLE)
    ) dut (
        .clk        (clk),
        .Reset      (Reset),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .occupancy  (occupancy)
`ifdef PIPE_STAGE_STATS_EN
        ,
        .stall_count(stall_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int pass_cnt  = 0;
    int total_cnt = 0;

    // Reference model: a queue of held payloads (the scoreboard).
    logic [WIDTH-1:0] sb[$];
    int               exp_stall = 0;
    int               accepted  = 0;
    int               consumed  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end else begin
            pass_cnt++;
        end
    endtask

    task automatic check_model(input string tag);
        logic [WIDTH-1:0] exp_data;
        exp_data = (sb.size() != 0) ? sb[0] : BUBBLE;
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(sb.size() != 0));
        chk({tag, ".out_data"},  out_data,        exp_data);
        chk({tag, ".in_ready"},  32'(in_ready),  32'(sb.size() != DEPTH));
        chk({tag, ".occupancy"}, 32'(occupancy), 32'(sb.size()));
`ifdef PIPE_STAGE_STATS_EN
        chk({tag, ".stall_count"}, 32'(stall_count), 32'(exp_stall));
`endif
    endtask

    // One clock cycle: drive at the falling edge, update the model for the
    // rising edge, then compare DUT against model 1 time unit after it.
    task automatic cycle(input logic iv, input logic [WIDTH-1:0] d,
                         input logic ordy, input logic fl, input string tag);
        logic do_push;
        logic do_pop;
        @(negedge clk);
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        do_push = iv && (sb.size() != DEPTH);
        do_pop  = ordy && (sb.size() != 0);
        if (iv && (sb.size() == DEPTH) && exp_stall < 16'hFFFF) exp_stall++;
        if (fl) begin
            sb.delete();
        end else begin
            if (do_pop) begin
                void'(sb.pop_front());
                consumed++;
            end
            if (do_push) begin
                sb.push_back(d);
                accepted++;
            end
        end
        @(posedge clk);
        #1;
        check_model(tag);
    endtask

    typedef struct {
        logic             iv;
        logic [WIDTH-1:0] d;
        logic             ordy;
        logic             fl;
        int               occ;
        logic             ov;
        logic [WIDTH-1:0] od;
        logic             ir;
    } vec_t;

    vec_t vecs[16];

    initial begin
        // Hand-derived expectations after each edge.
        vecs[0]  = '{1'b1, 32'h11, 1'b1, 1'b0, 1, 1'b1, 32'h11,  1'b1}; // stream
        vecs[1]  = '{1'b1, 32'h22, 1'b1, 1'b0, 1, 1'b1, 32'h22,  1'b1};
        vecs[2]  = '{1'b1, 32'h33, 1'b1, 1'b0, 1, 1'b1, 32'h33,  1'b1};
        vecs[3]  = '{1'b0, 32'h0,  1'b1, 1'b0, 0, 1'b0, BUBBLE,  1'b1};
        vecs[4]  = '{1'b1, 32'hA,  1'b0, 1'b0, 1, 1'b1, 32'hA,   1'b1}; // backpressure
        vecs[5]  = '{1'b1, 32'hB,  1'b0, 1'b0, 2, 1'b1, 32'hA,   1'b0};
        vecs[6]  = '{1'b1, 32'hC,  1'b0, 1'b0, 2, 1'b1, 32'hA,   1'b0};
        vecs[7]  = '{1'b1, 32'hC,  1'b1, 1'b0, 1, 1'b1, 32'hB,   1'b1}; // full: pop only
        vecs[8]  = '{1'b1, 32'hC,  1'b1, 1'b0, 1, 1'b1, 32'hC,   1'b1};
        vecs[9]  = '{1'b0, 32'h0,  1'b1, 1'b0, 0, 1'b0, BUBBLE,  1'b1};
        vecs[10] = '{1'b1, 32'h55, 1'b0, 1'b0, 1, 1'b1, 32'h55,  1'b1}; // flush at full
        vecs[11] = '{1'b1, 32'h66, 1'b0, 1'b0, 2, 1'b1, 32'h55,  1'b0};
        vecs[12] = '{1'b1, 32'h77, 1'b0, 1'b1, 0, 1'b0, BUBBLE,  1'b1};
        vecs[13] = '{1'b1, 32'h88, 1'b0, 1'b0, 1, 1'b1, 32'h88,  1'b1}; // flush drops push
        vecs[14] = '{1'b1, 32'h99, 1'b1, 1'b1, 0, 1'b0, BUBBLE,  1'b1};
        vecs[15] = '{1'b0, 32'h0,  1'b0, 1'b0, 0, 1'b0, BUBBLE,  1'b1};

        Reset     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        #2;
        check_model("reset");
        @(negedge clk);
        @(negedge clk);
        Reset = 1'b0;
        cycle(1'b0, 32'h0, 1'b0, 1'b0, "idle");

        for (int i = 0; i < 16; i++) begin
            cycle(vecs[i].iv, vecs[i].d, vecs[i].ordy, vecs[i].fl, $sformatf("vec%0d", i));
            chk($sformatf("vec%0d.tbl_occ", i), 32'(occupancy), 32'(vecs[i].occ));
            chk($sformatf("vec%0d.tbl_ov", i),  32'(out_valid), 32'(vecs[i].ov));
            chk($sformatf("vec%0d.tbl_od", i),  out_data,        vecs[i].od);
            chk($sformatf("vec%0d.tbl_ir", i),  32'(in_ready),  32'(vecs[i].ir));
        end

        // Asynchronous reset between edges with one entry held.
        cycle(1'b1, 32'h5A, 1'b0, 1'b0, "pre_rst");
        chk("pre_rst.occ1", 32'(occupancy), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        #2;
        Reset = 1'b1;
        #1;
        sb.delete();
        exp_stall = 0;
        chk("async_rst.out_valid", 32'(out_valid), 32'd0);
        chk("async_rst.out_data",  out_data,        BUBBLE);
        chk("async_rst.occupancy", 32'(occupancy), 32'd0);
        chk("async_rst.in_ready",  32'(in_ready),  32'd1);
        @(negedge clk);
        Reset = 1'b0;

        // Pointer wrap: 4*DEPTH payloads with irregular stalls on both sides.
        accepted = 0;
        consumed = 0;
        begin
            int n = 0;
            while (accepted < 4 * DEPTH && n < 200) begin
                cycle(n % 3 != 1, 32'hC000 + 32'(accepted), (n % 4) < 2, 1'b0, "wrap");
                n++;
            end
            while (sb.size() != 0 && n < 240) begin
                cycle(1'b0, 32'h0, 1'b1, 1'b0, "drain");
                n++;
            end
        end
        chk("wrap.accepted", 32'(accepted), 32'(4 * DEPTH));
        chk("wrap.consumed", 32'(consumed), 32'(4 * DEPTH));

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
